acc_drain_requant: RTL and testbench
====================================

// Module: acc_drain_requant
// PURPOSE
//  Drains one accumulator column bank after a tile completes: sweeps addr 0..DEPTH-1 on the bank's async-read port.
//  Requantises each ACC_WIDTH psum to signed OUT_WIDTH (multiply, rounding shift, zero-point add, saturate).
//  Clears each entry via an overwrite-with-0 write so the bank is ready for the next tile.
//  Sits directly downstream of the column bank; streams results to the output buffer / PPU with valid/ready.
// PARAMETERS
//  ACC_WIDTH    32  accumulator width (matches bank)
//  DEPTH        12  entries drained per sweep (<= 2**ADDR_W)
//  ADDR_W       4   bank address width
//  MULT_WIDTH   16  signed requant multiplier width
//  SHIFT_WIDTH  5   right-shift amount width (0..31)
//  OUT_WIDTH    8   signed output width
// PORTS
//  clk           in   1            clock
//  rst           in   1            asynchronous reset, active-high
//  start         in   1            begin sweep; sampled only in IDLE
//  cfg_mult      in   MULT_WIDTH   signed multiplier, latched at start
//  cfg_shift     in   SHIFT_WIDTH  right shift, latched at start
//  cfg_zp        in   OUT_WIDTH    signed zero point, latched at start
//  busy          out  1            high from accepted start until done
//  done          out  1            1-cycle pulse after last output handshake
//  bank_addr     out  ADDR_W       read/clear address to bank
//  bank_rd_data  in   ACC_WIDTH    bank async read data for bank_addr (same cycle)
//  bank_wr_en    out  1            clear-write strobe
//  bank_acc_mode out  1            constant 0 (overwrite)
//  bank_psum     out  ACC_WIDTH    constant 0 (clear value)
//  out_valid     out  1            output holds valid data
//  out_ready     in   1            consumer accepts when valid&ready
//  out_data      out  OUT_WIDTH    requantised value
//  out_last      out  1            marks entry DEPTH-1
// BEHAVIOUR
//  Reset: state IDLE; busy, done, bank_wr_en, out_valid, out_last = 0; bank_addr, out_data = 0; pipe valids cleared.
//  Reset mid-sweep: abandon sweep immediately; no done pulse. Entries already cleared stay cleared.
//  FSM:
//   IDLE->DRAIN on start (latch cfg, addr=0).
//   DRAIN->FLUSH when entry DEPTH-1 is captured.
//   FLUSH->DONE when the last output handshakes.
//   DONE->IDLE after 1 cycle (done=1). start outside IDLE is ignored.
//  Advance: adv = !out_valid | out_ready.
//   All pipe registers hold when adv=0; bank_addr holds; bank_wr_en=0.
//  Stage S0 (capture), in DRAIN when adv=1:
//   Register bank_rd_data and the last flag; assert bank_wr_en=1 in the same cycle (clears that addr at clock edge).
//   Increment bank_addr. Each entry is read exactly once and cleared exactly once.
//  Stage S1: prod = signed(acc) * signed(cfg_mult), full ACC_WIDTH+MULT_WIDTH bits, registered.
//  Stage S2, output register:
//   r = (shift==0) ? prod : (prod + (1<<(shift-1))) >>> shift (round half up, arithmetic shift).
//   v = r + signext(cfg_zp).
//   Saturate v to [-2**(OUT_WIDTH-1), 2**(OUT_WIDTH-1)-1].
//   out_last follows its entry.
//  Latency: first out_valid 3 cycles after the start cycle with out_ready=1. Throughput 1/cycle.
//   Full sweep DEPTH+3 cycles, then done on the next cycle.
//  Backpressure: out_data/out_last stable while out_valid & !out_ready. No loss or duplication under any ready pattern.
//  Bank contents are not touched outside DRAIN. Caller must not write the bank while busy.
// TESTING
//  1. Bank=0..11, mult=16384, shift=15, zp=3, ready=1 -> out 3,4,4,5,5,6,6,7,7,8,8,9; last on 12th; done 1 cycle after; bank all 0.
//  2. acc=-3, mult=1, shift=1, zp=0 -> -1 (round half up). acc=3 -> 2. shift=0, acc=5 -> 5.
//  3. Saturation: acc=100000, mult=1, shift=0 -> 127. acc=-100000 -> -128. zp=10 with acc=120 -> 127.
//  4. Backpressure: ready toggles 1,0,0,1 repeating -> 12 outputs in order, held stable while stalled; each entry cleared once.
//  5. start pulsed mid-sweep -> ignored; cfg changes mid-sweep -> no effect on outputs.
//  6. rst asserted after 5 outputs -> all outputs 0 next cycle, no done; entries 0..6 zero; a new start completes a full sweep.

Source files
------------

// File: rtl/acc_drain_requant.sv
// Drains one accumulator column bank: reads and clears each entry, requantises the psum to a
// saturated signed OUT_WIDTH value and streams it out over valid/ready.
module acc_drain_requant #(
  parameter int ACC_WIDTH   = 32,
  parameter int DEPTH       = 12,
  parameter int ADDR_W      = 4,
  parameter int MULT_WIDTH  = 16,
  parameter int SHIFT_WIDTH = 5,
  parameter int OUT_WIDTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic signed [MULT_WIDTH-1:0]  cfg_mult,
  input  logic        [SHIFT_WIDTH-1:0] cfg_shift,
  input  logic signed [OUT_WIDTH-1:0]   cfg_zp,
  output logic                          busy,
  output logic                          done,
  output logic        [ADDR_W-1:0]      bank_addr,
  input  logic signed [ACC_WIDTH-1:0]   bank_rd_data,
  output logic                          bank_wr_en,
  output logic                          bank_acc_mode,
  output logic signed [ACC_WIDTH-1:0]   bank_psum,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_WIDTH-1:0]   out_data,
  output logic                          out_last
);

  localparam int PROD_W = ACC_WIDTH + MULT_WIDTH;
  localparam int EXT_W  = PROD_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic signed [EXT_W-1:0] OUT_MAX = EXT_W'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [EXT_W-1:0] OUT_MIN = EXT_W'(-(2 ** (OUT_WIDTH - 1)));

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH, S_DONE} state_t;

  state_t                         r_state;
  logic signed [MULT_WIDTH-1:0]   r_mult;
  logic        [SHIFT_WIDTH-1:0]  r_shift;
  logic signed [OUT_WIDTH-1:0]    r_zp;
  logic signed [ACC_WIDTH-1:0]    r_acc_p0;
  logic                           r_vld_p0;
  logic                           r_last_p0;
  logic signed [PROD_W-1:0]       r_prod_p1;
  logic                           r_vld_p1;
  logic                           r_last_p1;

  logic                           w_adv;
  logic                           w_hs_last;
  logic signed [PROD_W-1:0]       w_acc_ext;
  logic signed [PROD_W-1:0]       w_mult_ext;

  // Round half up, then arithmetic right shift; one guard bit keeps the rounding add exact.
  function automatic logic signed [EXT_W-1:0] round_shift(
    input logic signed [PROD_W-1:0]  prod,
    input logic        [SHIFT_WIDTH-1:0] sh
  );
    logic signed [EXT_W-1:0] v_ext;
    v_ext = EXT_W'(prod);
    if (sh == '0)
      return v_ext;
    return (v_ext + (EXT_W'(1) <<< (sh - SHIFT_WIDTH'(1)))) >>> sh;
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] saturate(
    input logic signed [EXT_W-1:0] v
  );
    if (v > OUT_MAX)
      return OUT_MAX[OUT_WIDTH-1:0];
    if (v < OUT_MIN)
      return OUT_MIN[OUT_WIDTH-1:0];
    return v[OUT_WIDTH-1:0];
  endfunction

  assign w_adv         = !out_valid | out_ready;
  assign w_hs_last     = out_valid & out_ready & out_last;
  assign bank_wr_en    = (r_state == S_DRAIN) & w_adv;
  assign bank_acc_mode = 1'b0;
  assign bank_psum     = '0;
  assign w_acc_ext     = PROD_W'(r_acc_p0);
  assign w_mult_ext    = PROD_W'(r_mult);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      bank_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_state   <= S_DRAIN;
            busy      <= 1'b1;
            bank_addr <= '0;
          end
        end
        S_DRAIN: begin
          if (w_adv) begin
            if (bank_addr == LAST_ADDR) begin
              r_state   <= S_FLUSH;
              bank_addr <= '0;
            end else begin
              bank_addr <= bank_addr + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (w_hs_last) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          done    <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Configuration is frozen for the whole sweep
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && start) begin
      r_mult  <= cfg_mult;
      r_shift <= cfg_shift;
      r_zp    <= cfg_zp;
    end
  end

  // Stage p0: capture read data; stage p1: full-width product
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_acc_p0  <= bank_rd_data;
      r_prod_p1 <= w_acc_ext * w_mult_ext;
    end
  end

  // Stage p2: output register; the whole pipe stalls together so nothing is lost or repeated
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p0  <= 1'b0;
      r_last_p0 <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (w_adv) begin
      r_vld_p0  <= (r_state == S_DRAIN);
      r_last_p0 <= (bank_addr == LAST_ADDR);
      r_vld_p1  <= r_vld_p0;
      r_last_p1 <= r_last_p0;
      out_valid <= r_vld_p1;
      out_last  <= r_vld_p1 & r_last_p1;
      out_data  <= r_vld_p1 ? saturate(round_shift(r_prod_p1, r_shift) + EXT_W'(r_zp)) : '0;
    end
  end

endmodule

// File: tb/tb_acc_drain_requant.sv
// Bench for acc_drain_requant: bank model, random sweeps and a real-arithmetic requant reference.
module tb_acc_drain_requant;

  localparam int N = 12;

  logic               clk;
  logic               rst;
  logic               start;
  logic signed [15:0] cfg_mult;
  logic        [4:0]  cfg_shift;
  logic signed [7:0]  cfg_zp;
  logic               busy;
  logic               done;
  logic        [3:0]  bank_addr;
  logic signed [31:0] bank_rd_data;
  logic               bank_wr_en;
  logic               bank_acc_mode;
  logic signed [31:0] bank_psum;
  logic               out_valid;
  logic               out_ready;
  logic signed [7:0]  out_data;
  logic               out_last;

  acc_drain_requant dut (
    .clk(clk), .rst(rst), .start(start), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
    .cfg_zp(cfg_zp), .busy(busy), .done(done), .bank_addr(bank_addr),
    .bank_rd_data(bank_rd_data), .bank_wr_en(bank_wr_en), .bank_acc_mode(bank_acc_mode),
    .bank_psum(bank_psum), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Bank model: async read, write on clock edge
  logic signed [31:0] mem      [N];
  logic signed [31:0] init_val [N];
  int                 clr_cnt  [N];
  logic               load;

  assign bank_rd_data = (bank_addr < 4'd12) ? mem[bank_addr] : 32'sd0;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < N; i++) begin
        mem[i]     <= init_val[i];
        clr_cnt[i] <= 0;
      end
    end else if (bank_wr_en && bank_addr < 4'd12) begin
      mem[bank_addr]     <= bank_acc_mode ? mem[bank_addr] + bank_psum : bank_psum;
      clr_cnt[bank_addr] <= clr_cnt[bank_addr] + 1;
    end
  end

  typedef struct { bit l; int d; } ent_t;
  ent_t got_q[$];
  int   done_cnt = 0;
  bit   stall_prev = 0;
  int   stall_d;
  bit   stall_l;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, stall_d);
        chk("stall_last", out_last, stall_l);
      end
      if (out_valid && out_ready) got_q.push_back('{out_last, int'(out_data)});
      if (done) done_cnt++;
      stall_prev = out_valid && !out_ready;
      stall_d    = out_data;
      stall_l    = out_last;
    end
  end

  int rmode = 0;
  int rph   = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rph++;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (rph % 4 == 0) || (rph % 4 == 3);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Reference: exact rational rounding of acc*mult / 2**shift, then zero point and clamp
  function automatic int ref_q(longint acc, longint m, int s, longint z);
    longint p, r, v;
    p = acc * m;
    if (s == 0) r = p;
    else        r = longint'($floor(real'(p) / (2.0 ** s) + 0.5));
    v = r + z;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return int'(v);
  endfunction

  task automatic load_bank();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic rand_bank();
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 2))
        0:       init_val[i] = 32'($urandom_range(0, 600)) - 32'sd300;
        1:       init_val[i] = 32'($urandom_range(0, 2097151)) - 32'sd1048576;
        default: init_val[i] = $urandom;
      endcase
    end
    load_bank();
  endtask

  task automatic run_sweep(input logic signed [15:0] m, input logic [4:0] s,
                           input logic signed [7:0] z, input int mode,
                           input bit disturb, input bit time_chk);
    int   cyc, first_v, d0;
    bit   seen_done;
    ent_t exp_q[$];
    for (int i = 0; i < N; i++)
      exp_q.push_back('{(i == N - 1), ref_q(init_val[i], m, int'(s), z)});
    rmode = mode;
    @(negedge clk);
    got_q.delete();
    d0 = done_cnt;
    cfg_mult = m; cfg_shift = s; cfg_zp = z; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    cyc = 0; first_v = -1; seen_done = 0;
    while (!seen_done && cyc < 400) begin
      if (disturb && cyc == 6) begin
        start = 1'b1; cfg_mult = 16'($urandom); cfg_shift = 5'($urandom); cfg_zp = 8'($urandom);
      end
      if (disturb && cyc == 7) start = 1'b0;
      @(negedge clk);
      cyc++;
      if (out_valid && first_v < 0) first_v = cyc;
      if (done) seen_done = 1;
    end
    chk("done_seen", seen_done, 1);
    if (time_chk) begin
      chk("first_valid_latency", first_v, 3);
      chk("done_cycle", cyc, N + 3);
    end
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_end", busy, 0);
    chk("done_count", done_cnt - d0, 1);
    chk("n_outputs", got_q.size(), N);
    for (int i = 0; i < N && i < got_q.size(); i++) begin
      chk($sformatf("data%0d", i), got_q[i].d, exp_q[i].d);
      chk($sformatf("last%0d", i), got_q[i].l, exp_q[i].l);
    end
    for (int i = 0; i < N; i++) begin
      chk($sformatf("cleared%0d", i), mem[i], 0);
      chk($sformatf("clr_once%0d", i), clr_cnt[i], 1);
    end
  endtask

  initial begin
    int t1 [N] = '{3, 4, 4, 5, 5, 6, 6, 7, 7, 8, 8, 9};
    int nv, d0, cyc;
    rst = 1'b1; start = 1'b0; load = 1'b0;
    cfg_mult = '0; cfg_shift = '0; cfg_zp = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", bank_wr_en, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_addr", bank_addr, 0);
    chk("rst_data", out_data, 0);
    chk("acc_mode", bank_acc_mode, 0);
    chk("psum", bank_psum, 0);
    rst = 1'b0;

    // Ramp bank with the 0.5 multiplier
    for (int i = 0; i < N; i++) init_val[i] = i;
    load_bank();
    run_sweep(16'sd16384, 5'd15, 8'sd3, 0, 0, 1);
    for (int i = 0; i < N && i < got_q.size(); i++) chk($sformatf("ramp%0d", i), got_q[i].d, t1[i]);

    // Rounding
    init_val = '{-3, 3, -5, 5, -1, 1, -2, 2, 0, 7, -7, 100};
    load_bank();
    run_sweep(16'sd1, 5'd1, 8'sd0, 0, 0, 1);
    if (got_q.size() >= 2) begin
      chk("round_m3", got_q[0].d, -1);
      chk("round_p3", got_q[1].d, 2);
    end

    // Saturation, shift 0 and zero point
    init_val = '{5, 100000, -100000, 120, -128, 127, 128, -129, 0, 1, -1, 42};
    load_bank();
    run_sweep(16'sd1, 5'd0, 8'sd0, 0, 0, 1);
    if (got_q.size() >= 3) begin
      chk("shift0", got_q[0].d, 5);
      chk("sat_pos", got_q[1].d, 127);
      chk("sat_neg", got_q[2].d, -128);
    end
    load_bank();
    run_sweep(16'sd1, 5'd0, 8'sd10, 0, 0, 1);
    if (got_q.size() >= 4) chk("zp_sat", got_q[3].d, 127);

    // Backpressure pattern 1,0,0,1
    rand_bank();
    run_sweep(16'($urandom_range(0, 4000)), 5'($urandom_range(4, 14)), 8'($urandom), 1, 0, 0);

    // Start and cfg changes during a sweep
    rand_bank();
    run_sweep(16'sd300, 5'd9, -8'sd7, 0, 1, 1);
    chk("no_restart", busy, 0);

    // Reset in the middle of a sweep
    rand_bank();
    rmode = 0;
    @(negedge clk);
    d0 = done_cnt;
    cfg_mult = 16'sd1; cfg_shift = 5'd0; cfg_zp = 8'sd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nv = 0; cyc = 0;
    while (nv < 5 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (out_valid) nv++;
    end
    chk("five_outputs_seen", nv, 5);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr_en", bank_wr_en, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_rst_no_done", done_cnt - d0, 0);
    for (int i = 0; i < N; i++) begin
      if (i < 7) chk($sformatf("rst_cleared%0d", i), mem[i], 0);
      else       chk($sformatf("rst_kept%0d", i), mem[i], init_val[i]);
    end
    rand_bank();
    run_sweep(16'($urandom), 5'($urandom_range(8, 31)), 8'($urandom), 0, 0, 1);

    // Random sweeps under random backpressure
    for (int k = 0; k < 6; k++) begin
      rand_bank();
      if (k % 2 == 0)
        run_sweep(16'($urandom), 5'($urandom), 8'($urandom), 2, 0, 0);
      else
        run_sweep(16'($urandom_range(0, 255)) - 16'sd128, 5'($urandom_range(0, 12)), 8'($urandom), 2, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
